// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the MIPS fetch and MEM stages.
// Grants one access at a time (data first), holds the request stable until MemReady, and aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRData,
    output logic          StallIF,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic [DW-1:0] DRData,
    output logic          StallMem,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemReady,
    output logic          Timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_e;

    localparam logic       WD_EN   = (TIMEOUT != 0);
    localparam logic [7:0] WD_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic          busy_s;
    logic          wd_fire_s;
    logic          grant_d_s;
    logic          grant_i_s;
    logic          to_idle_s;

    assign busy_s = (state_q != IDLE);

    // MemReady wins the race against the watchdog compare in the same cycle.
    assign wd_fire_s = WD_EN & busy_s & ~MemReady & (wait_cnt_q == WD_LAST);

    // Arbitration decision: which requester is granted this edge, or whether the port goes idle.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        to_idle_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (DReq) begin
                    grant_d_s = 1'b1;
                end else if (IReq) begin
                    grant_i_s = 1'b1;
                end else begin
                    to_idle_s = 1'b1;
                end
            end
            I_WAIT: begin
                // A fetch never chains into another fetch: the next PC only settles at this edge.
                if (MemReady) begin
                    grant_d_s = DReq;
                    to_idle_s = ~DReq;
                end else if (wd_fire_s) begin
                    to_idle_s = 1'b1;
                end else begin
                    to_idle_s = 1'b0;
                end
            end
            D_WAIT: begin
                if (MemReady) begin
                    grant_i_s = IReq;
                    to_idle_s = ~IReq;
                end else if (wd_fire_s) begin
                    to_idle_s = 1'b1;
                end else begin
                    to_idle_s = 1'b0;
                end
            end
            default: begin
                to_idle_s = 1'b1;
            end
        endcase
    end

    // Next-state and port-register update; address/data only move on a grant.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q | wd_fire_s;
        if (grant_d_s) begin
            state_d     = D_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = DWe;
            mem_addr_d  = DAddr;
            mem_wdata_d = DWData;
            wait_cnt_d  = 8'd0;
        end else if (grant_i_s) begin
            state_d     = I_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = IAddr;
            wait_cnt_d  = 8'd0;
        end else if (to_idle_s) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
        end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d  = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d  = wait_cnt_q;
        end
    end

    // State and memory-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign StallIF  = IReq & ~((state_q == I_WAIT) & MemReady);
    assign StallMem = DReq & ~((state_q == D_WAIT) & MemReady);
    assign IRData   = MemRData;
    assign DRData   = MemRData;
    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign Timeout  = timeout_q;

    mem_port_arbiter_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_req (mem_req_q),
        .busy    (busy_s),
        .timeout (timeout_q)
    );

endmodule

// Invariant checks on the arbiter state; carries no logic of its own.
module mem_port_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic mem_req,
    input logic busy,
    input logic timeout
);

    // MemReq is asserted exactly while an access is outstanding.
    a_req_matches_busy: assert property (@(posedge clk) disable iff (!rst_n) mem_req == busy);

    // The watchdog flag never clears outside reset.
    a_timeout_sticky: assert property (@(posedge clk) disable iff (!rst_n) timeout |=> timeout);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses the default watchdog, instance b uses TIMEOUT=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

    logic [31:0] irdata_a, drdata_a, mem_addr_a, mem_wdata_a;
    logic        stall_if_a, stall_mem_a, mem_req_a, mem_we_a, timeout_a;
    logic [31:0] irdata_b, drdata_b, mem_addr_b, mem_wdata_b;
    logic        stall_if_b, stall_mem_b, mem_req_b, mem_we_b, timeout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .IReq(i_req), .IAddr(i_addr), .IRData(irdata_a), .StallIF(stall_if_a),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWData(d_wdata),
        .DRData(drdata_a), .StallMem(stall_mem_a),
        .MemReq(mem_req_a), .MemWe(mem_we_a), .MemAddr(mem_addr_a), .MemWData(mem_wdata_a),
        .MemRData(mem_rdata), .MemReady(mem_ready), .Timeout(timeout_a)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .IReq(i_req), .IAddr(i_addr), .IRData(irdata_b), .StallIF(stall_if_b),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWData(d_wdata),
        .DRData(drdata_b), .StallMem(stall_mem_b),
        .MemReq(mem_req_b), .MemWe(mem_we_b), .MemAddr(mem_addr_b), .MemWData(mem_wdata_b),
        .MemRData(mem_rdata), .MemReady(mem_ready), .Timeout(timeout_b)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL rst_memreq got %b exp 0", mem_req_a); end
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL rst_memwe got %b exp 0", mem_we_a); end
        checks++; if (mem_addr_a !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr_a); end
        checks++; if (mem_wdata_a !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata_a); end
        checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", timeout_a); end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h11;
        next_cycle();
        #1;
        checks++; if (mem_req_a !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b exp 1", mem_req_a); end
        checks++; if (mem_addr_a !== 32'h44) begin errors++; $display("FAIL rst_pre_addr got %h exp 44", mem_addr_a); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b exp 0", mem_req_a); end
        checks++; if (mem_addr_a !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got %h exp 0", mem_addr_a); end
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b exp 0", mem_we_a); end
        checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout got %b exp 0", timeout_a); end
        checks++; if (stall_mem_a !== 1'b1) begin errors++; $display("FAIL rst_mid_stallmem got %b exp 1", stall_mem_a); end
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL rst_idle_req got %b exp 0", mem_req_a); end
        i_req = 1'b1; i_addr = 32'h20;
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b1) begin errors++; $display("FAIL rst_regrant_req got %b exp 1", mem_req_a); end
        checks++; if (mem_addr_a !== 32'h20) begin errors++; $display("FAIL rst_regrant_addr got %h exp 20", mem_addr_a); end
        i_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req = 1'b1; i_addr = 32'h0040_0000;
        @(negedge clk);
        checks++; if (stall_if_a !== 1'b1) begin errors++; $display("FAIL fetch_c0_stall got %b exp 1", stall_if_a); end
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL fetch_c0_req got %b exp 0", mem_req_a); end
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b1) begin errors++; $display("FAIL fetch_c1_req got %b exp 1", mem_req_a); end
        checks++; if (mem_addr_a !== 32'h0040_0000) begin errors++; $display("FAIL fetch_c1_addr got %h exp 00400000", mem_addr_a); end
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL fetch_c1_we got %b exp 0", mem_we_a); end
        checks++; if (stall_if_a !== 1'b0) begin errors++; $display("FAIL fetch_c1_stall got %b exp 0", stall_if_a); end
        checks++; if (irdata_a !== 32'hCAFE_0001) begin errors++; $display("FAIL fetch_c1_data got %h exp cafe0001", irdata_a); end
        next_cycle();
        i_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL fetch_c2_req got %b exp 0", mem_req_a); end
    endtask

    task automatic test_contention();
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (stall_mem_a !== 1'b1 || stall_if_a !== 1'b1) begin errors++; $display("FAIL cont_c0_stalls got %b%b exp 11", stall_mem_a, stall_if_a); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            mem_ready = (c == 3);
            @(negedge clk);
            checks++; if (mem_req_a !== 1'b1 || mem_we_a !== 1'b1) begin errors++; $display("FAIL cont_d_c%0d_req_we got %b%b exp 11", c, mem_req_a, mem_we_a); end
            checks++; if (mem_addr_a !== 32'h2000 || mem_wdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cont_d_c%0d_addr got %h/%h exp 2000/deadbeef", c, mem_addr_a, mem_wdata_a); end
            checks++; if (stall_mem_a !== (c != 3)) begin errors++; $display("FAIL cont_d_c%0d_stallmem got %b exp %b", c, stall_mem_a, (c != 3)); end
            checks++; if (stall_if_a !== 1'b1) begin errors++; $display("FAIL cont_d_c%0d_stallif got %b exp 1", c, stall_if_a); end
        end
        for (int c = 4; c <= 6; c++) begin
            next_cycle();
            d_req = 1'b0;
            mem_ready = (c == 6);
            mem_rdata = 32'h0BAD_F00D;
            @(negedge clk);
            checks++; if (mem_req_a !== 1'b1 || mem_we_a !== 1'b0) begin errors++; $display("FAIL cont_i_c%0d_req_we got %b%b exp 10", c, mem_req_a, mem_we_a); end
            checks++; if (mem_addr_a !== 32'h100) begin errors++; $display("FAIL cont_i_c%0d_addr got %h exp 100", c, mem_addr_a); end
            checks++; if (stall_if_a !== (c != 6)) begin errors++; $display("FAIL cont_i_c%0d_stallif got %b exp %b", c, stall_if_a, (c != 6)); end
        end
        checks++; if (irdata_a !== 32'h0BAD_F00D) begin errors++; $display("FAIL cont_irdata got %h exp 0badf00d", irdata_a); end
        next_cycle();
        i_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL cont_c7_req got %b exp 0", mem_req_a); end
    endtask

    task automatic test_load();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            mem_ready = (c == 5);
            mem_rdata = (c == 5) ? 32'h1234_5678 : 32'hFFFF_0000;
            @(negedge clk);
            checks++; if (mem_addr_a !== 32'h10) begin errors++; $display("FAIL load_c%0d_addr got %h exp 10", c, mem_addr_a); end
            checks++; if (stall_mem_a !== (c != 5)) begin errors++; $display("FAIL load_c%0d_stall got %b exp %b", c, stall_mem_a, (c != 5)); end
        end
        checks++; if (drdata_a !== 32'h1234_5678) begin errors++; $display("FAIL load_data got %h exp 12345678", drdata_a); end
        next_cycle();
        d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL load_c6_req got %b exp 0", mem_req_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall_if_a !== 1'b1 || mem_req_a !== 1'b0) begin errors++; $display("FAIL b2b_c0_idle_ready got %b%b exp 10", stall_if_a, mem_req_a); end
        next_cycle();
        mem_rdata = 32'h0000_0500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        @(negedge clk);
        checks++; if (stall_if_a !== 1'b0 || stall_mem_a !== 1'b1) begin errors++; $display("FAIL b2b_c1_stalls got %b%b exp 01", stall_if_a, stall_mem_a); end
        next_cycle();
        i_addr = 32'h504; mem_rdata = 32'h0000_0600;
        @(negedge clk);
        checks++; if (mem_addr_a !== 32'h600 || mem_we_a !== 1'b0) begin errors++; $display("FAIL b2b_c2_addr got %h/%b exp 600/0", mem_addr_a, mem_we_a); end
        checks++; if (stall_mem_a !== 1'b0 || stall_if_a !== 1'b1) begin errors++; $display("FAIL b2b_c2_stalls got %b%b exp 01", stall_mem_a, stall_if_a); end
        checks++; if (drdata_a !== 32'h0000_0600) begin errors++; $display("FAIL b2b_c2_data got %h exp 600", drdata_a); end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b1 || mem_addr_a !== 32'h504) begin errors++; $display("FAIL b2b_c3_fetch got %b/%h exp 1/504", mem_req_a, mem_addr_a); end
        checks++; if (stall_if_a !== 1'b0) begin errors++; $display("FAIL b2b_c3_stall got %b exp 0", stall_if_a); end
        next_cycle();
        i_addr = 32'h508;
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b0 || stall_if_a !== 1'b1) begin errors++; $display("FAIL b2b_c4_bubble got %b%b exp 01", mem_req_a, stall_if_a); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req_a !== 1'b1 || mem_addr_a !== 32'h508) begin errors++; $display("FAIL b2b_c5_fetch got %b/%h exp 1/508", mem_req_a, mem_addr_a); end
        next_cycle();
        i_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        i_req = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        checks++; if (mem_req_b !== 1'b0 || stall_if_b !== 1'b1) begin errors++; $display("FAIL wd_c0 got %b%b exp 01", mem_req_b, stall_if_b); end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (mem_req_b !== 1'b1 || timeout_b !== 1'b0) begin errors++; $display("FAIL wd_c%0d_req_to got %b%b exp 10", c, mem_req_b, timeout_b); end
            checks++; if (stall_if_b !== 1'b1) begin errors++; $display("FAIL wd_c%0d_stall got %b exp 1", c, stall_if_b); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req_b !== 1'b0 || timeout_b !== 1'b1) begin errors++; $display("FAIL wd_c5_req_to got %b%b exp 01", mem_req_b, timeout_b); end
        checks++; if (stall_if_b !== 1'b1) begin errors++; $display("FAIL wd_c5_stall got %b exp 1", stall_if_b); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_req_b !== 1'b1 || mem_addr_b !== 32'h300) begin errors++; $display("FAIL wd_c6_regrant got %b/%h exp 1/300", mem_req_b, mem_addr_b); end
        checks++; if (timeout_b !== 1'b1 || stall_if_b !== 1'b1) begin errors++; $display("FAIL wd_c6_sticky got %b%b exp 11", timeout_b, stall_if_b); end
        i_req = 1'b0;
    endtask

    task automatic test_timeout_race();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            mem_ready = (c == 4);
            mem_rdata = 32'h55AA_33CC;
            @(negedge clk);
            checks++; if (mem_req_b !== 1'b1) begin errors++; $display("FAIL race_c%0d_req got %b exp 1", c, mem_req_b); end
            checks++; if (stall_mem_b !== (c != 4)) begin errors++; $display("FAIL race_c%0d_stall got %b exp %b", c, stall_mem_b, (c != 4)); end
        end
        checks++; if (drdata_b !== 32'h55AA_33CC) begin errors++; $display("FAIL race_data got %h exp 55aa33cc", drdata_b); end
        next_cycle();
        d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_b !== 1'b0 || timeout_b !== 1'b0) begin errors++; $display("FAIL race_c5 got %b%b exp 00", mem_req_b, timeout_b); end
        next_cycle();
        @(negedge clk);
        checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL race_c6_timeout got %b exp 0", timeout_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_load();
        test_back_to_back();
        test_watchdog();
        test_timeout_race();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared, variable-latency memory port between the instruction-fetch stage and the memory (data) stage of the pipelined MIPS core. It latches each granted request, drives the memory handshake and returns read data. It also generates the fetch-side and memory-side stall requests that the hazard unit ORs into its own stall/flush signals. A watchdog aborts accesses the memory never acknowledges.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 255: max wait cycles per access, 0 disables watchdog, range 0..255.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- IReq  input  1  fetch request, held while StallIF=1.
- IAddr  input  AW  fetch address.
- IRData  output  DW  fetch data, valid when IReq=1 and StallIF=0.
- StallIF  output  1  fetch not yet served.
- DReq  input  1  data request (lw/sw in MEM stage), held while StallMem=1.
- DWe  input  1  1=store, 0=load.
- DAddr  input  AW  data address.
- DWData  input  DW  store data.
- DRData  output  DW  load data, valid when DReq=1 and StallMem=0.
- StallMem  output  1  data access not yet served.
- MemReq  output  1  memory request, registered.
- MemWe  output  1  memory write enable, registered.
- MemAddr  output  AW  memory address, registered.
- MemWData  output  DW  memory write data, registered.
- MemRData  input  DW  memory read data, valid with MemReady.
- MemReady  input  1  memory completes the current access this cycle.
- Timeout  output  1  sticky watchdog flag, cleared only by reset.

## Operation
- States: IDLE, I_WAIT, D_WAIT.
- IDLE, DReq=1: latch DAddr, DWe and DWData into MemAddr, MemWe and MemWData. Set MemReq=1 and go to D_WAIT. Data has priority over fetch.
- IDLE, DReq=0 and IReq=1: latch IAddr, set MemWe=0 and MemReq=1, and go to I_WAIT.
- IDLE with no request: stay, MemReq=0.
- X_WAIT with MemReady=1 (access complete):
  - From D_WAIT with IReq=1: latch the fetch and go directly to I_WAIT, with no idle cycle.
  - From I_WAIT with DReq=1: latch the data request and go directly to D_WAIT.
  - Otherwise: MemReq=0 and go to IDLE.
  - A fetch after a fetch always passes through IDLE, because the next PC is not valid until the completing edge.
- StallIF = IReq & ~(state==I_WAIT & MemReady). Combinational.
- StallMem = DReq & ~(state==D_WAIT & MemReady). Combinational.
- IRData and DRData are wired to MemRData. Store completion returns no data.
- Watchdog: an 8-bit WaitCnt clears on every grant and increments each wait cycle while MemReady=0. If TIMEOUT!=0 and WaitCnt==TIMEOUT-1 with MemReady=0:
  - set MemReq=0, set Timeout=1, go to IDLE;
  - the requester stays stalled and is re-arbitrated from IDLE, which is a retry.
- MemReady sampled in IDLE is ignored.
- MemAddr, MemWe and MemWData only change at a grant edge. They are stable for the whole wait.

## Timing
- Reset (asynchronous, immediate): state=IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, WaitCnt=0, Timeout=0.
- With a request pending at reset, StallIF and StallMem follow their equations, so they are 1.
- Reset asserted mid-access drops MemReq in the same cycle. The memory is required to tolerate an abandoned access.
- Minimum access (from IDLE):
  - request seen in cycle 0;
  - MemReq=1 in cycle 1;
  - if MemReady=1 in cycle 1, stall=0 in cycle 1 and the access completes at the end of cycle 1;
  - minimum latency is 2 cycles.
- Memory latency of N wait cycles means the stall is released in cycle N+1 after the request.
- Contention (both requests pending): D, then I back-to-back with no bubble, then the arbiter re-evaluates.
- Timeout fires after exactly TIMEOUT cycles with MemReq=1 and no MemReady. MemReq=0 in the following cycle (IDLE), and the re-grant follows one cycle later.
- MemReady arriving in the same cycle as the timeout compare counts as completion. The timeout does not fire.

## Test plan
- Reset: rst_n=0 mid-D_WAIT -> MemReq=0 and Timeout=0 immediately; state IDLE after release.
- Single fetch, 0-wait memory: IReq=1, IAddr=0x0040_0000, MemReady=1 whenever MemReq=1 -> MemAddr=0x0040_0000 in cycle 1, StallIF=1 in cycle 0 and 0 in cycle 1, IRData=MemRData.
- Contention: IReq=1 with IAddr=0x100, and DReq=1, DWe=1, DAddr=0x2000, DWData=0xDEADBEEF in cycle 0; memory has 2 wait states ->
  - write to 0x2000 with MemWe=1 first;
  - StallMem releases in cycle 3;
  - MemAddr=0x100 with MemWe=0 at cycle 4, with no IDLE cycle;
  - StallIF releases in cycle 6.
- Load data return: DReq=1, DWe=0, DAddr=0x10, MemRData=0x1234_5678 with MemReady in cycle 5 -> StallMem=0 in cycle 5 only, DRData=0x1234_5678, MemAddr stable 0x10 cycles 1-5.
- Watchdog: TIMEOUT=4, MemReady held 0 -> MemReq high cycles 1-4, Timeout=1 and MemReq=0 in cycle 5, re-grant with MemReq=1 in cycle 6, StallIF=1 throughout.
- Timeout race: TIMEOUT=4, MemReady=1 exactly in cycle 4 -> normal completion and Timeout stays 0.
